// File: rtl/controlador_serial_4bits_pkg.sv
// Shared definitions for the 4-bit serial transmit controller: state encodings,
// datapath width and the bit-count terminal value.
package controlador_serial_4bits_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Even parity over the data bits, i.e. the XOR of all of them.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/controlador_serial_4bits_shift_reg_4b.sv
// 4-bit load/shift register: parallel load when load is high, otherwise shift
// toward bit 0 with a zero entering bit 3. Asynchronous active-low clear.
module shift_reg_4b
  import controlador_serial_4bits_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= {1'b0, q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/controlador_serial_4bits.sv
// Sequencer that takes a 4-bit word via Start/Ready and sends it LSB first on SerOut.
// Optional trailing even-parity bit is compiled in with the CTRL_PARITY_EN macro.
module controlador_serial_4bits
  import controlador_serial_4bits_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
)
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Start,
  input  logic [DATA_W-1:0] D,
  output logic              Ready,
  output logic              Busy,
  output logic              Load,
  output logic              SerOut,
  output logic [CNT_W-1:0]  Count,
  output logic              Done
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  shift_q;
  logic               last_bit;

  shift_reg_4b u_shift_reg (
    .clk   (CLK),
    .clr_n (CLR),
    .load  (Load),
    .d     (D),
    .q     (shift_q)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The edge that moves the count from 3 to 4 is the last shift edge.
  assign last_bit = (count_q == (CNT_LAST - 3'd1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef CTRL_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_DONE;
`endif
        end
      end
      ST_PARITY: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      count_q <= '0;
    end else begin
      case (state)
        ST_SHIFT: count_q <= count_q + 3'd1;
        ST_DONE:  count_q <= '0;
        ST_IDLE:  count_q <= '0;
        default:  count_q <= count_q;
      endcase
    end
  end

`ifdef CTRL_PARITY_EN
  logic parity_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      parity_q <= 1'b0;
    end else if (Load) begin
      parity_q <= even_parity(D);
    end
  end
`endif

  always_comb begin
    SerOut = IDLE_LEVEL;
    case (state)
      ST_SHIFT: SerOut = shift_q[0];
`ifdef CTRL_PARITY_EN
      ST_PARITY: SerOut = parity_q;
`endif
      default: SerOut = IDLE_LEVEL;
    endcase
  end

  // CLR gates Load so the register never sees a load request while held in reset.
  assign Ready = (state == ST_IDLE);
  assign Load  = Start & Ready & CLR;
  assign Busy  = (state != ST_IDLE);
  assign Done  = (state == ST_DONE);
  assign Count = count_q;

  a_load_only_idle: assert property (@(posedge CLK) disable iff (!CLR) Load |-> Ready);
  a_done_to_idle:   assert property (@(posedge CLK) disable iff (!CLR) Done |=> Ready);
  a_count_range:    assert property (@(posedge CLK) disable iff (!CLR) Count <= CNT_LAST);

endmodule

// File: tb/tb_controlador_serial_4bits.sv
// Table-driven bench for controlador_serial_4bits, with two instances (IDLE_LEVEL 1 and 0)
// sharing stimulus; parity expectations follow CTRL_PARITY_EN.
module tb_controlador_serial_4bits;

`ifdef CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] d;

  logic       ready_h, busy_h, load_h, ser_h, done_h;
  logic [2:0] count_h;
  logic       ready_l, busy_l, load_l, ser_l, done_l;
  logic [2:0] count_l;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  controlador_serial_4bits #(.IDLE_LEVEL(1'b1)) dut_high (
    .CLK(clk), .CLR(clr), .Start(start), .D(d),
    .Ready(ready_h), .Busy(busy_h), .Load(load_h),
    .SerOut(ser_h), .Count(count_h), .Done(done_h)
  );

  controlador_serial_4bits #(.IDLE_LEVEL(1'b0)) dut_low (
    .CLK(clk), .CLR(clr), .Start(start), .D(d),
    .Ready(ready_l), .Busy(busy_l), .Load(load_l),
    .SerOut(ser_l), .Count(count_l), .Done(done_l)
  );

  typedef struct {
    logic       clr;
    logic       start;
    logic [3:0] d;
    logic       ready;
    logic       busy;
    logic       load;
    logic       done;
    logic       idl;
    logic       ser;
    logic [2:0] count;
  } vec_t;

  vec_t vecs[$];

  task automatic check_val(input string name, input int step,
                           input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic add_row(input logic c, input logic s, input logic [3:0] dv,
                         input logic rdy, input logic bsy, input logic ld,
                         input logic dn, input logic idl, input logic sr,
                         input logic [2:0] cnt);
    vec_t v;
    v.clr = c; v.start = s; v.d = dv;
    v.ready = rdy; v.busy = bsy; v.load = ld; v.done = dn;
    v.idl = idl; v.ser = sr; v.count = cnt;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input logic c, input logic s, input logic [3:0] dv, input logic ld);
    add_row(c, s, dv, 1'b1, 1'b0, ld, 1'b0, 1'b1, 1'b0, 3'd0);
  endtask

  // Rows for the cycles after an accept: four data bits (given by hand),
  // an optional parity cycle, and the DONE cycle.
  task automatic word_rows(input logic [3:0] bits, input logic par,
                           input logic s_during, input logic [3:0] d_during,
                           input logic s_done, input logic [3:0] d_done);
    for (int i = 0; i < 4; i++) begin
      add_row(1'b1, s_during, d_during, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits[i], 3'(i));
    end
    if (PAR) begin
      add_row(1'b1, s_during, d_during, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, par, 3'd4);
    end
    add_row(1'b1, s_done, d_done, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    clr   = v.clr;
    start = v.start;
    d     = v.d;
    #1;
  endtask

  task automatic check_output(input vec_t v, input int step);
    check_val("ready_h", step, ready_h, v.ready);
    check_val("busy_h",  step, busy_h,  v.busy);
    check_val("load_h",  step, load_h,  v.load);
    check_val("done_h",  step, done_h,  v.done);
    check_val("count_h", step, count_h, v.count);
    check_val("ser_h",   step, ser_h,   v.idl ? 1'b1 : v.ser);
    check_val("ready_l", step, ready_l, v.ready);
    check_val("busy_l",  step, busy_l,  v.busy);
    check_val("load_l",  step, load_l,  v.load);
    check_val("done_l",  step, done_l,  v.done);
    check_val("count_l", step, count_l, v.count);
    check_val("ser_l",   step, ser_l,   v.idl ? 1'b0 : v.ser);
  endtask

  initial begin
    bit seen;
    int cycles;

    clr   = 1'b0;
    start = 1'b0;
    d     = 4'b0000;

    // Reset, including Start high while CLR is low (no Load allowed).
    idle_row(1'b0, 1'b0, 4'b0000, 1'b0);
    idle_row(1'b0, 1'b1, 4'b1011, 1'b0);
    idle_row(1'b1, 1'b0, 4'b0000, 1'b0);

    // Word 1011: bits 1,1,0,1, parity 1; D changes after accept.
    idle_row(1'b1, 1'b1, 4'b1011, 1'b1);
    word_rows(4'b1011, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    idle_row(1'b1, 1'b0, 4'b0000, 1'b0);

    // Word 0100 with Start/D=0110 pushed during shifting: ignored.
    idle_row(1'b1, 1'b1, 4'b0100, 1'b1);
    word_rows(4'b0100, 1'b1, 1'b1, 4'b0110, 1'b0, 4'b0110);
    idle_row(1'b1, 1'b0, 4'b0110, 1'b0);
    idle_row(1'b1, 1'b0, 4'b0110, 1'b0);

    // Start held high: 0001 then 1000 back to back.
    idle_row(1'b1, 1'b1, 4'b0001, 1'b1);
    word_rows(4'b0001, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000);
    idle_row(1'b1, 1'b1, 4'b1000, 1'b1);
    word_rows(4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    idle_row(1'b1, 1'b0, 4'b0000, 1'b0);

    // Word 0111: bits 1,1,1,0, parity 1.
    idle_row(1'b1, 1'b1, 4'b0111, 1'b1);
    word_rows(4'b0111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    idle_row(1'b1, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
    end

    // Asynchronous reset in the middle of word 1111.
    @(negedge clk);
    clr = 1'b1; start = 1'b1; d = 4'b1111;
    @(negedge clk);
    start = 1'b0; d = 4'b0000;
    @(negedge clk);
    #1;
    check_val("midword_count", 100, count_h, 3'd1);
    check_val("midword_ser",   100, ser_h,   1'b1);
    #2;
    start = 1'b1;
    clr   = 1'b0;
    #1;
    check_val("rst_ser_h",  101, ser_h,   1'b1);
    check_val("rst_ser_l",  101, ser_l,   1'b0);
    check_val("rst_count",  101, count_h, 3'd0);
    check_val("rst_ready",  101, ready_h, 1'b1);
    check_val("rst_busy",   101, busy_h,  1'b0);
    check_val("rst_done",   101, done_h,  1'b0);
    check_val("rst_load",   101, load_h,  1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b1; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (done_h || !ready_h) seen = 1'b1;
    end
    check_val("no_done_after_rst", 102, seen, 1'b0);

    // CLR released together with Start: accepted on the first edge with CLR high.
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; d = 4'b0110;
    #1;
    check_val("release_load", 103, load_h, 1'b1);
    @(negedge clk);
    start = 1'b0; d = 4'b0000;
    #1;
    check_val("release_busy", 104, busy_h, 1'b1);
    check_val("release_bit0", 104, ser_h,  1'b0);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 2; i <= 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_h) begin
        seen   = 1'b1;
        cycles = i;
      end
    end
    check_val("release_done_seen", 105, seen, 1'b1);
    check_val("release_done_cycle", 106, 4'(cycles), PAR ? 4'd6 : 4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
